// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks in-flight register writers in the stages after D (1 = E, 2 = M,
// 3 = W). For each D-stage source it finds the youngest pending writer and
// decides whether to stall or which stage to forward from.
// Optional feature: define MDU_STALL_EN to add a multiply/divide busy
// counter that stalls HI/LO readers while the unit is occupied.
module hazard_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int T_W    = 3,
   parameter int STAGES = 3,
   parameter int MD_LAT = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_W-1:0]           d_rs,
   input  logic [ADDR_W-1:0]           d_rt,
   input  logic [T_W-1:0]              d_tuse_rs,
   input  logic [T_W-1:0]              d_tuse_rt,
   input  logic [ADDR_W-1:0]           d_a3,
   input  logic                        d_regwrite,
   input  logic [T_W-1:0]              d_tnew,
   input  logic                        d_is_md,
   input  logic                        md_start,
   output logic                        stall,
   output logic [$clog2(STAGES+1)-1:0] fwd_rs_sel,
   output logic [$clog2(STAGES+1)-1:0] fwd_rt_sel,
   output logic                        md_busy
);

   localparam int SEL_W = $clog2(STAGES + 1);

   // Tnew counts down as an entry ages, but never below zero.
   function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
      return (t == '0) ? t : t - T_W'(1);
   endfunction

   // Scoreboard entries, one per tracked stage.
   logic              r_valid [1:STAGES];
   logic [ADDR_W-1:0] r_a3    [1:STAGES];
   logic [T_W-1:0]    r_tnew  [1:STAGES];

   // Values each stage will take on the next edge.
   logic              w_nxt_valid [1:STAGES];
   logic [ADDR_W-1:0] w_nxt_a3    [1:STAGES];
   logic [T_W-1:0]    w_nxt_tnew  [1:STAGES];

   // Per-source lookup: index 0 is rs, index 1 is rt.
   logic [ADDR_W-1:0] w_src_addr  [0:1];
   logic [T_W-1:0]    w_src_tuse  [0:1];
   logic              w_src_stall [0:1];
   logic [SEL_W-1:0]  w_src_sel   [0:1];

   logic w_stall;
   logic w_md_busy;
   logic w_md_stall;

   assign w_src_addr[0] = d_rs;
   assign w_src_addr[1] = d_rt;
   assign w_src_tuse[0] = d_tuse_rs;
   assign w_src_tuse[1] = d_tuse_rt;

   genvar gi;

   // Next-state of each stage: stage 1 takes the D instruction (or a bubble
   // while stalled), later stages take the aged entry of the stage before.
   generate
      for (gi = 1; gi <= STAGES; gi++) begin : g_next
         if (gi == 1) begin : g_head
            // Writes to r0 or non-writing instructions never create a hazard.
            assign w_nxt_valid[gi] = ~w_stall & d_regwrite & (d_a3 != '0);
            assign w_nxt_a3[gi]    = d_a3;
            assign w_nxt_tnew[gi]  = sat_dec(d_tnew);
         end else begin : g_body
            assign w_nxt_valid[gi] = r_valid[gi-1];
            assign w_nxt_a3[gi]    = r_a3[gi-1];
            assign w_nxt_tnew[gi]  = sat_dec(r_tnew[gi-1]);
         end
      end
   endgenerate

   // Advance the scoreboard one stage per cycle; the oldest entry drops off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_a3[k]    <= '0;
            r_tnew[k]  <= '0;
         end
      end else begin
         for (int k = 1; k <= STAGES; k++) begin
            r_valid[k] <= w_nxt_valid[k];
            r_a3[k]    <= w_nxt_a3[k];
            r_tnew[k]  <= w_nxt_tnew[k];
         end
      end
   end

   // Hazard evaluation, identical and independent for each source operand.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic             w_found;
         logic [SEL_W-1:0] w_stage;
         logic [T_W-1:0]   w_tnew;

         // Pick the youngest valid writer of this source; scanning from the
         // oldest stage down lets a younger match override an older one.
         always_comb begin
            w_found = 1'b0;
            w_stage = '0;
            w_tnew  = '0;
            for (int k = STAGES; k >= 1; k--) begin
               if (r_valid[k] && (r_a3[k] == w_src_addr[gi]) &&
                   (w_src_addr[gi] != '0)) begin
                  w_found = 1'b1;
                  w_stage = SEL_W'(k);
                  w_tnew  = r_tnew[k];
               end
            end
         end

         // Stall if the value arrives later than the instruction needs it;
         // forward only once the producer has the value in hand.
         assign w_src_stall[gi] = w_found & (w_tnew > w_src_tuse[gi]);
         assign w_src_sel[gi]   = (w_found && (w_tnew == '0)) ? w_stage : '0;
      end
   endgenerate

`ifdef MDU_STALL_EN
   localparam int CNT_W = $clog2(MD_LAT + 1);

   logic [CNT_W-1:0] r_md_cnt;

   // Busy down-counter; a new launch restarts the full latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_md_cnt <= '0;
      end else if (md_start) begin
         r_md_cnt <= CNT_W'(MD_LAT);
      end else if (r_md_cnt != '0) begin
         r_md_cnt <= r_md_cnt - CNT_W'(1);
      end
   end

   // The launch cycle itself already counts as busy.
   assign w_md_busy  = (r_md_cnt != '0) | md_start;
   assign w_md_stall = d_is_md & w_md_busy;
`else
   localparam int unused_md_lat = MD_LAT;
   logic w_unused_md;

   assign w_unused_md = &{1'b0, md_start, d_is_md};
   assign w_md_busy   = 1'b0;
   assign w_md_stall  = 1'b0;
`endif

   assign w_stall = w_src_stall[0] | w_src_stall[1] | w_md_stall;

   // Reset forces every output low at once, without waiting for an edge.
   assign stall      = ~reset & w_stall;
   assign md_busy    = ~reset & w_md_busy;
   assign fwd_rs_sel = reset ? '0 : w_src_sel[0];
   assign fwd_rt_sel = reset ? '0 : w_src_sel[1];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed scenarios plus randomized traffic checked against a history-based
// reference model (an instruction issued j cycles ago sits in stage j with
// max(tnew - j, 0) cycles left).
module tb_hazard_scoreboard;

   localparam int ADDR_W = 5;
   localparam int T_W    = 3;
   localparam int STAGES = 3;
   localparam int MD_LAT = 5;
   localparam int SEL_W  = $clog2(STAGES + 1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] d_rs = '0;
   logic [ADDR_W-1:0] d_rt = '0;
   logic [T_W-1:0]    d_tuse_rs = '0;
   logic [T_W-1:0]    d_tuse_rt = '0;
   logic [ADDR_W-1:0] d_a3 = '0;
   logic              d_regwrite = 1'b0;
   logic [T_W-1:0]    d_tnew = '0;
   logic              d_is_md = 1'b0;
   logic              md_start = 1'b0;
   logic              stall;
   logic [SEL_W-1:0]  fwd_rs_sel;
   logic [SEL_W-1:0]  fwd_rt_sel;
   logic              md_busy;

   hazard_scoreboard #(
      .ADDR_W(ADDR_W), .T_W(T_W), .STAGES(STAGES), .MD_LAT(MD_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_a3(d_a3), .d_regwrite(d_regwrite), .d_tnew(d_tnew),
      .d_is_md(d_is_md), .md_start(md_start),
      .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: issue history, youngest first.
   typedef struct {
      bit v;
      int a3;
      int tnew;
   } ent_t;
   ent_t hist[$];
   int   cyc = 0;
   int   last_start = 0;
   bit   have_start = 1'b0;

   bit e_stall;
   bit e_busy;
   int e_fwd_rs;
   int e_fwd_rt;

   task automatic model_reset();
      hist.delete();
      have_start = 1'b0;
      cyc = 0;
   endtask

   task automatic lookup(input int addr, output int stage, output int rem);
      stage = 0;
      rem = 0;
      for (int j = 1; j <= hist.size(); j++) begin
         if (stage == 0 && addr != 0 && hist[j-1].v && hist[j-1].a3 == addr) begin
            stage = j;
            rem = (hist[j-1].tnew > j) ? hist[j-1].tnew - j : 0;
         end
      end
   endtask

   task automatic model_eval();
      int s_rs, r_rs, s_rt, r_rt;
      lookup(int'(d_rs), s_rs, r_rs);
      lookup(int'(d_rt), s_rt, r_rt);
`ifdef MDU_STALL_EN
      e_busy = md_start || (have_start && (cyc - last_start) <= MD_LAT);
`else
      e_busy = 1'b0;
`endif
      e_stall = (s_rs != 0 && r_rs > int'(d_tuse_rs)) ||
                (s_rt != 0 && r_rt > int'(d_tuse_rt)) ||
                (d_is_md && e_busy);
      e_fwd_rs = (s_rs != 0 && r_rs == 0) ? s_rs : 0;
      e_fwd_rt = (s_rt != 0 && r_rt == 0) ? s_rt : 0;
   endtask

   // Account for the edge that follows the current cycle.
   task automatic commit();
      ent_t e;
      e.v = !e_stall && d_regwrite && (d_a3 != '0);
      e.a3 = int'(d_a3);
      e.tnew = int'(d_tnew);
      hist.push_front(e);
      if (hist.size() > STAGES) void'(hist.pop_back());
      if (md_start) begin
         have_start = 1'b1;
         last_start = cyc;
      end
      $display("cyc %0d a3=%0d rw=%0d tnew=%0d rs=%0d/%0d rt=%0d/%0d md=%0d/%0d -> stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d",
               cyc, d_a3, d_regwrite, d_tnew, d_rs, d_tuse_rs, d_rt, d_tuse_rt,
               d_is_md, md_start, stall, fwd_rs_sel, fwd_rt_sel, md_busy);
      cyc++;
   endtask

   task automatic set_d(input int a3, input int rw, input int tnew,
                        input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                        input int is_md, input int start);
      d_a3 = ADDR_W'(a3);
      d_regwrite = (rw != 0);
      d_tnew = T_W'(tnew);
      d_rs = ADDR_W'(rs);
      d_tuse_rs = T_W'(tuse_rs);
      d_rt = ADDR_W'(rt);
      d_tuse_rt = T_W'(tuse_rt);
      d_is_md = (is_md != 0);
      md_start = (start != 0);
   endtask

   // Apply D inputs at the falling edge and settle; the model follows.
   task automatic drive_d(input int a3, input int rw, input int tnew,
                          input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                          input int is_md, input int start);
      @(negedge clk);
      set_d(a3, rw, tnew, rs, tuse_rs, rt, tuse_rt, is_md, start);
      #1;
      model_eval();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
         commit();
      end
   endtask

   // Deassert reset at a falling edge; the next edge loads the given D inputs.
   task automatic release_reset(input int a3, input int rw, input int tnew);
      @(negedge clk);
      reset = 1'b0;
      set_d(a3, rw, tnew, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      model_eval();
      commit();
   endtask

   task automatic test_reset();
      @(negedge clk);
      set_d(4, 1, 3, 4, 0, 4, 0, 1, 1);
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0d expected 0", stall); end
      n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d expected 0", md_busy); end
      n_cmp++; if (fwd_rs_sel !== '0) begin n_err++; $display("FAIL reset_fwd_rs: got %0d expected 0", fwd_rs_sel); end
      n_cmp++; if (fwd_rt_sel !== '0) begin n_err++; $display("FAIL reset_fwd_rt: got %0d expected 0", fwd_rt_sel); end
      // First edge after release loads a3=4 with tnew 3 into stage 1.
      release_reset(4, 1, 3);
      drive_d(0, 0, 0, 4, 0, 0, 0, 0, 0);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL first_load_stall: got %0d expected 1", stall); end
      commit();
   endtask

   task automatic test_load_use();
      idle_cycles(MD_LAT + STAGES);
      drive_d(8, 1, 3, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(0, 0, 0, 8, 1, 0, 0, 0, 0);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall1: got %0d expected 1", stall); end
      commit();
      drive_d(0, 0, 0, 8, 1, 0, 0, 0, 0);
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_use_stall2: got %0d expected 0", stall); end
      n_cmp++; if (fwd_rs_sel !== '0) begin n_err++; $display("FAIL load_use_fwd2: got %0d expected 0", fwd_rs_sel); end
      commit();
      drive_d(0, 0, 0, 8, 1, 0, 0, 0, 0);
      n_cmp++; if (fwd_rs_sel !== SEL_W'(e_fwd_rs)) begin n_err++; $display("FAIL load_use_fwd3: got %0d expected %0d", fwd_rs_sel, e_fwd_rs); end
      commit();
   endtask

   task automatic test_alu_forward();
      idle_cycles(STAGES);
      drive_d(5, 1, 1, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(0, 0, 0, 0, 0, 5, 1, 0, 0);
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_fwd_stall: got %0d expected 0", stall); end
      n_cmp++; if (fwd_rt_sel !== SEL_W'(1)) begin n_err++; $display("FAIL alu_fwd_rt: got %0d expected 1", fwd_rt_sel); end
      commit();
   endtask

   task automatic test_youngest();
      idle_cycles(STAGES);
      drive_d(3, 1, 1, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(3, 1, 1, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(0, 0, 0, 3, 0, 0, 0, 0, 0);
      n_cmp++; if (fwd_rs_sel !== SEL_W'(1)) begin n_err++; $display("FAIL youngest_fwd_rs: got %0d expected 1", fwd_rs_sel); end
      commit();
      // Younger writer still pending while an older one is ready: stall on the younger.
      idle_cycles(STAGES);
      drive_d(6, 1, 1, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(6, 1, 4, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(0, 0, 0, 6, 1, 6, 3, 0, 0);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL youngest_pending_stall: got %0d expected 1", stall); end
      n_cmp++; if (fwd_rs_sel !== '0) begin n_err++; $display("FAIL youngest_pending_fwd: got %0d expected 0", fwd_rs_sel); end
      commit();
   endtask

   task automatic test_zero_reg();
      idle_cycles(STAGES);
      drive_d(0, 1, 4, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_reg_stall: got %0d expected 0", stall); end
      n_cmp++; if (fwd_rs_sel !== '0) begin n_err++; $display("FAIL zero_reg_fwd: got %0d expected 0", fwd_rs_sel); end
      commit();
   endtask

   task automatic test_md();
      idle_cycles(MD_LAT + STAGES);
      drive_d(0, 0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++; if (md_busy !== e_busy) begin n_err++; $display("FAIL md_launch_busy: got %0d expected %0d", md_busy, e_busy); end
      commit();
      for (int i = 1; i <= MD_LAT + 1; i++) begin
         drive_d(0, 0, 0, 0, 0, 0, 0, 1, 0);
         n_cmp++; if (stall !== e_stall) begin n_err++; $display("FAIL md_stall_c%0d: got %0d expected %0d", i, stall, e_stall); end
         n_cmp++; if (md_busy !== e_busy) begin n_err++; $display("FAIL md_busy_c%0d: got %0d expected %0d", i, md_busy, e_busy); end
         commit();
      end
      // Relaunch at cycle 3 extends busy through cycle 8.
      drive_d(0, 0, 0, 0, 0, 0, 0, 0, 1);
      commit();
      for (int i = 1; i <= 9; i++) begin
         drive_d(0, 0, 0, 0, 0, 0, 0, 1, (i == 3) ? 1 : 0);
         n_cmp++; if (stall !== e_stall) begin n_err++; $display("FAIL md_reload_stall_c%0d: got %0d expected %0d", i, stall, e_stall); end
         commit();
      end
   endtask

   task automatic test_reset_mid_stall();
      idle_cycles(MD_LAT + STAGES);
      drive_d(8, 1, 3, 0, 0, 0, 0, 0, 0);
      commit();
      drive_d(0, 0, 0, 8, 0, 0, 0, 1, 1);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mid_stall_pre: got %0d expected 1", stall); end
      #1;
      reset = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_stall_drop: got %0d expected 0", stall); end
      n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL mid_stall_busy: got %0d expected 0", md_busy); end
      n_cmp++; if (fwd_rs_sel !== '0) begin n_err++; $display("FAIL mid_stall_fwd: got %0d expected 0", fwd_rs_sel); end
      release_reset(0, 0, 0);
      drive_d(0, 0, 0, 8, 0, 8, 0, 0, 0);
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL post_reset_stall: got %0d expected 0", stall); end
      n_cmp++; if (fwd_rs_sel !== '0) begin n_err++; $display("FAIL post_reset_fwd: got %0d expected 0", fwd_rs_sel); end
      commit();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1 : 0);
         n_cmp++; if (stall !== e_stall) begin n_err++; $display("FAIL rand_stall_%0d: got %0d expected %0d", i, stall, e_stall); end
         n_cmp++; if (fwd_rs_sel !== SEL_W'(e_fwd_rs)) begin n_err++; $display("FAIL rand_fwd_rs_%0d: got %0d expected %0d", i, fwd_rs_sel, e_fwd_rs); end
         n_cmp++; if (fwd_rt_sel !== SEL_W'(e_fwd_rt)) begin n_err++; $display("FAIL rand_fwd_rt_%0d: got %0d expected %0d", i, fwd_rt_sel, e_fwd_rt); end
         n_cmp++; if (md_busy !== e_busy) begin n_err++; $display("FAIL rand_busy_%0d: got %0d expected %0d", i, md_busy, e_busy); end
         commit();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_alu_forward();
      test_youngest();
      test_zero_reg();
      test_md();
      test_reset_mid_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
